speaker_serializer: RTL and testbench

Serialises the stereo 16-bit samples produced by `buzzer_control` (`audio_left`, `audio_right`) into a left-justified serial audio stream for the board's external audio DAC. It generates the DAC's master clock (MCLK), bit clock (SCK) and word-select (LRCK), and shifts the data line (SDIN). Samples are captured once per frame so upstream changes never corrupt a word mid-transmission. It sits directly downstream of `buzzer_control` and drives the top-level audio pins.

---
 rtl/audio_pkg.sv | 24 ++
 rtl/speaker_serializer_if.sv | 25 ++
 rtl/speaker_serializer_clk_gen.sv | 32 +++
 rtl/speaker_serializer.sv | 48 ++++
 tb/tb_speaker_serializer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared constants for the DAC serial audio path: sample width, frame
// counter width, which counter bits become the DAC clocks, and the mute word.
package audio_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int FRAME_CNT_W = 9;

    localparam int MCLK_BIT = 1;
    localparam int SCK_BIT  = 3;
    localparam int LRCK_BIT = 8;

    // cnt[7:4] counts the bit slot inside a 16-bit word
    localparam int BIT_SEL_LSB = 4;
    localparam int BIT_SEL_W   = $clog2(SAMPLE_W);

    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = '1;
    localparam logic [SAMPLE_W-1:0]    MUTE_WORD  = 16'h0000;

    // Slot 0 carries the MSB: left-justified, MSB first.
    function automatic logic [BIT_SEL_W-1:0] msb_first_index(input logic [BIT_SEL_W-1:0] slot);
        return BIT_SEL_W'(SAMPLE_W - 1) - slot;
    endfunction

endpackage

// File: rtl/speaker_serializer_if.sv
// Sample bus between buzzer_control (master) and speaker_serializer (slave).
// The slave returns sample_tick so upstream can see when its values are taken.
interface speaker_serializer_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] audio_left;
    logic [SAMPLE_W-1:0] audio_right;
    logic                mute;
    logic                sample_tick;

    modport master (
        output audio_left,
        output audio_right,
        output mute,
        input  sample_tick
    );

    modport slave (
        input  audio_left,
        input  audio_right,
        input  mute,
        output sample_tick
    );

endinterface

// File: rtl/speaker_serializer_clk_gen.sv
// Free-running 9-bit frame counter. The DAC clocks are raw counter bits, so
// they are glitch-free and phase-locked to the data slot counter.
module audio_clk_gen
    import audio_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    output logic                 mclk,
    output logic                 sck,
    output logic                 lrck,
    output logic                 sample_tick,
    output logic [BIT_SEL_W-1:0] bit_slot
);

    logic [FRAME_CNT_W-1:0] cnt;

    // Frame position: wraps 511 -> 0 on its own, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign mclk        = cnt[MCLK_BIT];
    assign sck         = cnt[SCK_BIT];
    assign lrck        = cnt[LRCK_BIT];
    assign bit_slot    = cnt[BIT_SEL_LSB +: BIT_SEL_W];
    assign sample_tick = (cnt == FRAME_LAST);

endmodule

// File: rtl/speaker_serializer.sv
// Left-justified stereo serializer for the external audio DAC. Samples are
// captured once per 512-cycle frame so upstream changes never split a word.
module speaker_serializer
    import audio_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    speaker_serializer_if.slave  bus,
    output logic                 audio_mclk,
    output logic                 audio_sck,
    output logic                 audio_lrck,
    output logic                 audio_sdin
);

    logic                 tick;
    logic [BIT_SEL_W-1:0] bit_slot;
    logic [BIT_SEL_W-1:0] idx;
    logic [SAMPLE_W-1:0]  left_hold;
    logic [SAMPLE_W-1:0]  right_hold;

    audio_clk_gen u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .mclk        (audio_mclk),
        .sck         (audio_sck),
        .lrck        (audio_lrck),
        .sample_tick (tick),
        .bit_slot    (bit_slot)
    );

    assign bus.sample_tick = tick;

    // Capture both channels at the frame boundary; mute is only looked at here
    // so it always takes effect on whole frames. Reset beats a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_hold  <= '0;
            right_hold <= '0;
        end else if (tick) begin
            left_hold  <= bus.mute ? MUTE_WORD : bus.audio_left;
            right_hold <= bus.mute ? MUTE_WORD : bus.audio_right;
        end
    end

    assign idx        = msb_first_index(bit_slot);
    assign audio_sdin = audio_lrck ? right_hold[idx] : left_hold[idx];

endmodule

// File: tb/tb_speaker_serializer.sv
// Self-checking bench for speaker_serializer. A frame-position model derived
// from the stream format predicts every output; scenario tasks check the
// directed cases with constant expectations.
module tb_speaker_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mclk, sck, lrck, sdin;

    speaker_serializer_if bus_if ();

    speaker_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .audio_mclk (mclk),
        .audio_sck  (sck),
        .audio_lrck (lrck),
        .audio_sdin (sdin)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: position within the frame and the words being sent.
    int          m_pos = 0;
    logic [15:0] m_l   = 16'h0;
    logic [15:0] m_r   = 16'h0;

    always @(posedge clk) begin
        if (rst) begin
            m_pos <= 0;
            m_l   <= 16'h0;
            m_r   <= 16'h0;
        end else begin
            if (m_pos == 511) begin
                m_l <= bus_if.mute ? 16'h0 : bus_if.audio_left;
                m_r <= bus_if.mute ? 16'h0 : bus_if.audio_right;
            end
            m_pos <= (m_pos + 1) % 512;
        end
    end

    function automatic logic exp_sdin();
        logic [15:0] word;
        word = (m_pos >= 256) ? m_r : m_l;
        return word[15 - ((m_pos % 256) / 16)];
    endfunction

    // Walk one whole frame starting at position 0, sampling SDIN at each SCK
    // rise (position 8 of each 16-cycle slot). mute is driven high only in the
    // cycle at mute_pos; audio_left changes to chg_left at chg_pos.
    task automatic collect_frame(input int mute_pos, input int chg_pos,
                                 input logic [15:0] chg_left,
                                 output logic [15:0] l, output logic [15:0] r);
        l = 16'h0;
        r = 16'h0;
        for (int i = 0; i < 512; i++) begin
            if ((i % 16) == 8) begin
                if (i < 256) l = {l[14:0], sdin};
                else         r = {r[14:0], sdin};
            end
            bus_if.mute = (i == mute_pos);
            if (i == chg_pos) bus_if.audio_left = chg_left;
            @(negedge clk);
        end
        bus_if.mute = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.audio_left  = 16'hFFFF;
        bus_if.audio_right = 16'hFFFF;
        bus_if.mute        = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (mclk !== 1'b0) begin failures++; $display("FAIL reset_mclk got=%b exp=0", mclk); end
        if (sck  !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", sck); end
        if (lrck !== 1'b0) begin failures++; $display("FAIL reset_lrck got=%b exp=0", lrck); end
        if (sdin !== 1'b0) begin failures++; $display("FAIL reset_sdin got=%b exp=0", sdin); end
        if (bus_if.sample_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", bus_if.sample_tick); end
        rst = 1'b0;
    endtask

    task automatic test_known_frame();
        logic [15:0] l, r;
        bus_if.audio_left  = 16'hA5F0;
        bus_if.audio_right = 16'h0F5A;
        collect_frame(-1, -1, 16'h0, l, r);
        checks += 2;
        if (l !== 16'h0000) begin failures++; $display("FAIL first_frame_left got=%h exp=0000", l); end
        if (r !== 16'h0000) begin failures++; $display("FAIL first_frame_right got=%h exp=0000", r); end
        collect_frame(-1, -1, 16'h0, l, r);
        checks += 2;
        if (l !== 16'hA5F0) begin failures++; $display("FAIL second_frame_left got=%h exp=a5f0", l); end
        if (r !== 16'h0F5A) begin failures++; $display("FAIL second_frame_right got=%h exp=0f5a", r); end
    endtask

    task automatic test_free_run();
        logic pm, ps, pl;
        int   lm, ls, ll;
        int   nm, ns, nl, nt;
        pm = mclk; ps = sck; pl = lrck;
        lm = -1; ls = -1; ll = -1;
        nm = 0; ns = 0; nl = 0; nt = 0;
        for (int i = 0; i < 2048; i++) begin
            checks += 5;
            if (mclk !== (((m_pos / 2) % 2) == 1)) begin failures++; $display("FAIL run_mclk pos=%0d got=%b", m_pos, mclk); end
            if (sck  !== (((m_pos / 8) % 2) == 1)) begin failures++; $display("FAIL run_sck pos=%0d got=%b", m_pos, sck); end
            if (lrck !== (m_pos >= 256)) begin failures++; $display("FAIL run_lrck pos=%0d got=%b", m_pos, lrck); end
            if (sdin !== exp_sdin()) begin failures++; $display("FAIL run_sdin pos=%0d got=%b exp=%b", m_pos, sdin, exp_sdin()); end
            if (bus_if.sample_tick !== (m_pos == 511)) begin failures++; $display("FAIL run_tick pos=%0d got=%b", m_pos, bus_if.sample_tick); end
            if (bus_if.sample_tick === 1'b1) nt++;
            if (i > 0) begin
                if (!pm && mclk) begin
                    if (lm >= 0) begin checks++; if (i - lm != 4) begin failures++; $display("FAIL mclk_period got=%0d exp=4", i - lm); end end
                    lm = i; nm++;
                end
                if (!ps && sck) begin
                    if (ls >= 0) begin checks++; if (i - ls != 16) begin failures++; $display("FAIL sck_period got=%0d exp=16", i - ls); end end
                    ls = i; ns++;
                end
                if (!pl && lrck) begin
                    if (ll >= 0) begin checks++; if (i - ll != 512) begin failures++; $display("FAIL lrck_period got=%0d exp=512", i - ll); end end
                    ll = i; nl++;
                end
                if (lrck !== pl) begin
                    checks++;
                    if (!(ps === 1'b1 && sck === 1'b0)) begin failures++; $display("FAIL lrck_edge_vs_sck got_sck=%b%b exp=10", ps, sck); end
                end
            end
            pm = mclk; ps = sck; pl = lrck;
            bus_if.audio_left  = 16'($urandom);
            bus_if.audio_right = 16'($urandom);
            bus_if.mute        = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        bus_if.mute = 1'b0;
        checks += 4;
        if (nm != 512) begin failures++; $display("FAIL mclk_rises got=%0d exp=512", nm); end
        if (ns != 128) begin failures++; $display("FAIL sck_rises got=%0d exp=128", ns); end
        if (nl != 4)   begin failures++; $display("FAIL lrck_rises got=%0d exp=4", nl); end
        if (nt != 4)   begin failures++; $display("FAIL tick_count got=%0d exp=4", nt); end
    endtask

    task automatic test_mid_frame_change();
        logic [15:0] l, r;
        bus_if.audio_left  = 16'h8000;
        bus_if.audio_right = 16'h5555;
        collect_frame(-1, -1, 16'h0, l, r);
        collect_frame(-1, 100, 16'hFFFF, l, r);
        checks += 2;
        if (l !== 16'h8000) begin failures++; $display("FAIL change_cur_left got=%h exp=8000", l); end
        if (r !== 16'h5555) begin failures++; $display("FAIL change_cur_right got=%h exp=5555", r); end
        collect_frame(-1, -1, 16'h0, l, r);
        checks++;
        if (l !== 16'hFFFF) begin failures++; $display("FAIL change_next_left got=%h exp=ffff", l); end
    endtask

    task automatic test_mute();
        logic [15:0] l, r;
        bus_if.audio_left  = 16'h7FFF;
        bus_if.audio_right = 16'h7FFF;
        collect_frame(511, -1, 16'h0, l, r);
        collect_frame(300, -1, 16'h0, l, r);
        checks += 2;
        if (l !== 16'h0000) begin failures++; $display("FAIL mute_cap_left got=%h exp=0000", l); end
        if (r !== 16'h0000) begin failures++; $display("FAIL mute_cap_right got=%h exp=0000", r); end
        collect_frame(-1, -1, 16'h0, l, r);
        checks += 2;
        if (l !== 16'h7FFF) begin failures++; $display("FAIL mute_mid_left got=%h exp=7fff", l); end
        if (r !== 16'h7FFF) begin failures++; $display("FAIL mute_mid_right got=%h exp=7fff", r); end
    endtask

    task automatic test_mid_reset();
        logic [15:0] l, r, vl, vr;
        vl = 16'($urandom) | 16'h8001;
        vr = 16'($urandom) | 16'h8001;
        bus_if.audio_left  = vl;
        bus_if.audio_right = vr;
        collect_frame(-1, -1, 16'h0, l, r);
        for (int i = 0; i < 140; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (mclk !== 1'b0) begin failures++; $display("FAIL midrst_mclk got=%b exp=0", mclk); end
        if (sck  !== 1'b0) begin failures++; $display("FAIL midrst_sck got=%b exp=0", sck); end
        if (lrck !== 1'b0) begin failures++; $display("FAIL midrst_lrck got=%b exp=0", lrck); end
        if (sdin !== 1'b0) begin failures++; $display("FAIL midrst_sdin got=%b exp=0", sdin); end
        if (bus_if.sample_tick !== 1'b0) begin failures++; $display("FAIL midrst_tick got=%b exp=0", bus_if.sample_tick); end
        rst = 1'b0;
        collect_frame(-1, -1, 16'h0, l, r);
        checks += 2;
        if (l !== 16'h0000) begin failures++; $display("FAIL midrst_left got=%h exp=0000", l); end
        if (r !== 16'h0000) begin failures++; $display("FAIL midrst_right got=%h exp=0000", r); end
        collect_frame(-1, -1, 16'h0, l, r);
        checks += 2;
        if (l !== vl) begin failures++; $display("FAIL midrst_next_left got=%h exp=%h", l, vl); end
        if (r !== vr) begin failures++; $display("FAIL midrst_next_right got=%h exp=%h", r, vr); end
    endtask

    task automatic test_reset_at_capture();
        logic [15:0] l, r;
        bus_if.audio_left  = 16'h1234;
        bus_if.audio_right = 16'h1234;
        for (int i = 0; i < 511; i++) @(negedge clk);
        checks++;
        if (bus_if.sample_tick !== 1'b1) begin failures++; $display("FAIL capture_tick got=%b exp=1", bus_if.sample_tick); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        collect_frame(-1, -1, 16'h0, l, r);
        checks += 2;
        if (l !== 16'h0000) begin failures++; $display("FAIL rstcap_left got=%h exp=0000", l); end
        if (r !== 16'h0000) begin failures++; $display("FAIL rstcap_right got=%h exp=0000", r); end
        collect_frame(-1, -1, 16'h0, l, r);
        checks += 2;
        if (l !== 16'h1234) begin failures++; $display("FAIL rstcap_next_left got=%h exp=1234", l); end
        if (r !== 16'h1234) begin failures++; $display("FAIL rstcap_next_right got=%h exp=1234", r); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_known_frame();
        test_free_run();
        test_mid_frame_change();
        test_mute();
        test_mid_reset();
        test_reset_at_capture();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
